mul_seq: RTL and testbench
==========================

# mul_seq

Iterative shift-and-add unsigned multiplier for the datapath layer built on the gate library. Each partial product is a bitwise AND of the multiplicand with one multiplier bit; the block accumulates one partial product per clock. It consumes the AND-gate primitives, feeds the ALU and CPU stages, and uses a start/busy/done handshake.

## Interface
- `WIDTH`, default 16: operand width in bits; result width is 2*WIDTH.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: request a multiply; sampled only in IDLE or DONE.
- `a` input, WIDTH bits: multiplicand, captured on the accepting edge.
- `b` input, WIDTH bits: multiplier, captured on the accepting edge.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse; `out` is valid from this cycle.
- `out` output, 2*WIDTH bits: product, held until the next result is written.

## Operation
- States:
  - IDLE: after reset.
  - RUN: accumulating.
  - DONE: single cycle, then returns to IDLE.
- Accept: in IDLE or DONE with `start`=1, the edge performs these loads and enters RUN:
  - mcand := zero-extended `a` (2*WIDTH bits)
  - mplier := `b`
  - acc := 0
  - count := 0
- RUN step, once per edge:
  - acc := acc + (mcand AND {2W{mplier[0]}})
  - mcand := mcand << 1
  - mplier := mplier >> 1
  - count := count + 1
- Leave RUN after the step with count = WIDTH-1. On that same edge: `out` := final acc, `done` := 1, state := DONE.
- Arithmetic: unsigned and modulo 2^(2W). No overflow is possible.
- `start` is ignored in RUN. `a`/`b` changes after acceptance have no effect.
- `start` in DONE is accepted: DONE→RUN directly, so back-to-back operation has no idle gap.
- Reset is synchronous and wins over everything. It aborts any operation in progress and resets `out`, `busy` and `done`.

## Timing
- Reset values: `out`=0, `busy`=0, `done`=0, state=IDLE, acc/mcand/mplier/count=0.
- Latency: accepting edge E0 sets `busy`=1. `done`=1 and the new `out` appear after edge E0+WIDTH, with `busy`=0 in that same cycle.
- `done` is high for exactly one cycle unless a new start is accepted (it then drops on the next edge).
- Throughput: one result per WIDTH+1 cycles with `start` held high.
- `busy` and `done` are never high together.
- `out` changes only on the edge that raises `done`, or on reset.

## Configuration
- `MUL_SEQ_EARLY_EXIT_EN` defined: RUN also terminates after any step where the shifted-out mplier becomes zero. Latency is then max(1, position of the highest set bit of `b` + 1) cycles (`b`=0 gives 1 cycle). The result is identical.
- Macro undefined: latency is always exactly WIDTH RUN cycles, independent of data.

## Structure
- Package `mul_seq_pkg`:
  - state enum `mul_state_t` {IDLE, RUN, DONE}
  - default width constant `MUL_WIDTH_DEFAULT`=16
- Sub-module `and_bus`: 2*WIDTH-bit AND of a vector with a replicated bit. It is built from the library AND gate and generates the partial product.
- Counter width is $clog2(WIDTH).

## Test plan
- Reset is applied mid-RUN (`a`=100, `b`=200). On the next edge: `out`=0, `busy`=0, `done`=0. No `done` pulse follows.
- `a`=3, `b`=5, WIDTH=16, macro off: `done` pulses exactly 16 edges after acceptance with `out`=15. `busy` is high for 16 cycles.
- `a`=16'hFFFF, `b`=16'hFFFF: `out`=32'hFFFE0001.
- `a`=1234, `b`=0 and `a`=0, `b`=1234: `out`=0 in both cases. With the macro on, `done` comes 1 edge after acceptance; with it off, 16 edges after.
- `start` is held high continuously with two operand pairs, (7,6) then (9,9):
  - `out`=42, then `out`=81.
  - The second accept occurs on the `done` cycle of the first.
  - `a`/`b` toggled during RUN do not alter the results.
- Macro on, `b`=16'h0008: `done` comes 4 edges after acceptance. Random 1000-pair sweep against a reference model: every `out` matches a*b in both configurations.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

   localparam int MUL_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/and_bus.sv
// Partial-product generator: each output bit is one 2-input AND gate between a vector bit and a shared select bit.
module and_bus #(
   parameter int W = 32
) (
   input  logic [W-1:0] vec,
   input  logic         sel,
   output logic [W-1:0] prod
);

   genvar i;
   generate
      for (i = 0; i < W; i++) begin : g_and
         assign prod[i] = vec[i] & sel;
      end
   endgenerate

endmodule

// File: rtl/mul_seq.sv
// Unsigned shift-and-add multiplier, one partial product per clock, start/busy/done handshake.
// Define MUL_SEQ_EARLY_EXIT_EN to end the run as soon as the remaining multiplier bits are all zero.
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] out
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   mul_state_t      state;
   logic [PW-1:0]   mcand;
   logic [PW-1:0]   acc;
   logic [PW-1:0]   pp;
   logic [PW-1:0]   acc_next;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] mplier_next;
   logic [CW-1:0]   count;
   logic            last_step;

   and_bus #(.W(PW)) u_pp (
      .vec  (mcand),
      .sel  (mplier[0]),
      .prod (pp)
   );

   assign acc_next    = acc + pp;
   assign mplier_next = mplier >> 1;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   // Once no set multiplier bits remain, further steps would only add zero.
   assign last_step = (count == CW'(WIDTH - 1)) || (mplier_next == '0);
`else
   assign last_step = (count == CW'(WIDTH - 1));
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         out    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  mcand  <= {{WIDTH{1'b0}}, a};
                  mplier <= b;
                  acc    <= '0;
                  count  <= '0;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mcand  <= mcand << 1;
               mplier <= mplier_next;
               count  <= count + 1'b1;
               if (last_step) begin
                  out   <= acc_next;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases plus a random sweep against an arithmetic model.
module tb_mul_seq;

   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .out   (out)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference latency in RUN cycles, from the operand alone.
   function automatic int exp_lat(input logic [W-1:0] y);
`ifdef MUL_SEQ_EARLY_EXIT_EN
      int hb;
      hb = 0;
      for (int i = 0; i < W; i++)
         if (y[i]) hb = i + 1;
      return (hb == 0) ? 1 : hb;
`else
      return W;
`endif
   endfunction

   function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] xe;
      logic [2*W-1:0] ye;
      xe = {{W{1'b0}}, x};
      ye = {{W{1'b0}}, y};
      return xe * ye;
   endfunction

   // Start a multiply on the next edge; start stays high on return.
   task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      start = 1'b1;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      check_eq("accept_busy", busy, 1);
      check_eq("accept_done_low", done, 0);
   endtask

   // Called just after the accepting edge; scrambles a/b each RUN cycle.
   task automatic wait_done(output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      while (lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         check_eq("busy_done_excl", busy & done, 0);
         if (done) break;
         if (busy) busy_n++;
         a = W'($urandom);
         b = W'($urandom);
      end
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, inout logic [2*W-1:0] last);
      int lat;
      int bn;
      accept(x, y);
      start = 1'b0;
      check_eq("out_held", out, last);
      wait_done(lat, bn);
      check_eq("latency", lat, exp_lat(y));
      check_eq("product", out, exp_prod(x, y));
      check_eq("busy_cycles", bn, lat - 1);
      last = exp_prod(x, y);
   endtask

   initial begin
      logic [2*W-1:0] last;
      int lat;
      int bn;
      bit seen;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      last  = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out", out, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(16'd3, 16'd5, last);
      check_eq("prod_3x5", out, 32'd15);
      run_op(16'hFFFF, 16'hFFFF, last);
      check_eq("prod_max", out, 32'hFFFE0001);
      run_op(16'd1234, 16'd0, last);
      run_op(16'd0, 16'd1234, last);
      run_op(W'($urandom), 16'h0008, last);

      // Back-to-back with start held: second accept lands on the first done cycle.
      accept(16'd7, 16'd6);
      wait_done(lat, bn);
      a = 16'd9;
      b = 16'd9;
      check_eq("b2b_lat1", lat, exp_lat(16'd6));
      check_eq("b2b_out1", out, 32'd42);
      @(posedge clk);
      #1;
      check_eq("b2b_accept_busy", busy, 1);
      check_eq("b2b_accept_done", done, 0);
      check_eq("b2b_out_held", out, 32'd42);
      wait_done(lat, bn);
      start = 1'b0;
      check_eq("b2b_lat2", lat, exp_lat(16'd9));
      check_eq("b2b_out2", out, 32'd81);
      last = 32'd81;

      // Reset in the middle of a run.
      accept(16'd100, 16'd200);
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("midrst_out", out, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      check_eq("midrst_no_done", seen, 0);
      last = '0;

      for (int i = 0; i < 1000; i++)
         run_op(W'($urandom), W'($urandom), last);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
